sram_load_decode_sequencer: RTL

SRAM_LOAD_DECODE_SEQUENCER -- requirements
Module: sram_load_decode_sequencer

---
 rtl/sram_load_decode_sequencer_pkg.sv | 20 ++
 rtl/uart_idle_timer.sv | 36 +++
 rtl/sram_load_decode_sequencer.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/sram_load_decode_sequencer_pkg.sv
// Shared state encoding and client-index helpers for the SRAM load/decode sequencer.
package define_state;

  localparam int unsigned MAX_CLIENTS = 4;
  localparam int unsigned IDX_W       = 2;

  // 3-bit encoding is driven straight onto the status LEDs
  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_UART_EN  = 3'd1,
    S_UART_RX  = 3'd2,
    S_CL_START = 3'd3,
    S_CL_RUN   = 3'd4
  } top_state_type;

  function automatic logic [MAX_CLIENTS-1:0] client_onehot(input logic [IDX_W-1:0] idx);
    client_onehot = MAX_CLIENTS'(1) << idx;
  endfunction

endpackage

// File: rtl/uart_idle_timer.sv
// Saturating idle counter; expired is high while the count sits at LIMIT-1.
module uart_idle_timer #(
  parameter int unsigned WIDTH = 26,
  parameter int unsigned LIMIT = 50000000
) (
  input  logic CLOCK_50_I,
  input  logic resetn,
  input  logic clear,
  output logic expired
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(LIMIT - 1);

  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_next;

  // Hold at LAST instead of wrapping so a long idle never looks like fresh activity
  always_comb begin
    w_next = r_count;
    if (clear)
      w_next = '0;
    else if (r_count != LAST)
      w_next = r_count + WIDTH'(1);
  end

  always_ff @(posedge CLOCK_50_I or negedge resetn) begin
    if (!resetn) begin
      r_count <= '0;
      expired <= 1'b0;
    end else begin
      r_count <= w_next;
      expired <= (w_next == LAST);
    end
  end

endmodule

// File: rtl/sram_load_decode_sequencer.sv
// Sequences a UART SRAM load followed by in-order decode clients, arbitrating SRAM ownership.
module sram_load_decode_sequencer
  import define_state::*;
#(
  parameter int unsigned ADDR_W         = 18,
  parameter int unsigned DATA_W         = 16,
  parameter int unsigned NUM_CLIENTS    = 3,
  parameter int unsigned TIMEOUT_CYCLES = 50000000,
  parameter int unsigned CLIENT_WDOG    = 2**24
) (
  input  logic                          CLOCK_50_I,
  input  logic                          resetn,
  input  logic                          load_req,
  input  logic                          uart_rx_n,
  input  logic                          decode_req,
  input  logic [ADDR_W-1:0]             uart_addr,
  input  logic [DATA_W-1:0]             uart_wdata,
  input  logic                          uart_we_n,
  output logic                          uart_init,
  output logic                          uart_enable,
  input  logic [ADDR_W-1:0]             vga_addr,
  output logic                          vga_enable,
  output logic [NUM_CLIENTS-1:0]        cl_start,
  input  logic [NUM_CLIENTS-1:0]        cl_done,
  input  logic [NUM_CLIENTS*ADDR_W-1:0] cl_addr,
  input  logic [NUM_CLIENTS*DATA_W-1:0] cl_wdata,
  input  logic [NUM_CLIENTS-1:0]        cl_we_n,
  output logic [ADDR_W-1:0]             sram_addr,
  output logic [DATA_W-1:0]             sram_wdata,
  output logic                          sram_we_n,
  output logic [2:0]                    state,
  output logic [1:0]                    active_client,
  output logic                          wdog_error
);

  localparam int unsigned TIMER_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned WDOG_W  = (CLIENT_WDOG > 2) ? $clog2(CLIENT_WDOG) : 1;
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(CLIENT_WDOG - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_CLIENTS - 1);

  top_state_type           r_state;
  logic [IDX_W-1:0]        r_idx;
  logic [WDOG_W-1:0]       r_wdog;
  logic                    w_expired;
  logic [MAX_CLIENTS-1:0]  w_onehot;
  logic [MAX_CLIENTS-1:0]  w_done_pad;
  logic [MAX_CLIENTS-1:0]  w_we_n_pad;
  logic [ADDR_W-1:0]       w_cl_addr_a  [MAX_CLIENTS];
  logic [DATA_W-1:0]       w_cl_wdata_a [MAX_CLIENTS];

  // Pad client buses to MAX_CLIENTS so idx can select without out-of-range slices
  for (genvar g = 0; g < MAX_CLIENTS; g++) begin : g_pad
    if (g < NUM_CLIENTS) begin : g_real
      assign w_done_pad[g]   = cl_done[g];
      assign w_we_n_pad[g]   = cl_we_n[g];
      assign w_cl_addr_a[g]  = cl_addr[g*ADDR_W +: ADDR_W];
      assign w_cl_wdata_a[g] = cl_wdata[g*DATA_W +: DATA_W];
    end else begin : g_absent
      assign w_done_pad[g]   = 1'b0;
      assign w_we_n_pad[g]   = 1'b1;
      assign w_cl_addr_a[g]  = '0;
      assign w_cl_wdata_a[g] = '0;
    end
  end

  assign w_onehot      = client_onehot(r_idx);
  assign state         = r_state;
  assign active_client = r_idx;

  uart_idle_timer #(
    .WIDTH (TIMER_W),
    .LIMIT (TIMEOUT_CYCLES)
  ) u_idle_timer (
    .CLOCK_50_I (CLOCK_50_I),
    .resetn     (resetn),
    .clear      (uart_init | ~uart_we_n),
    .expired    (w_expired)
  );

  always_ff @(posedge CLOCK_50_I or negedge resetn) begin
    if (!resetn) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_wdog      <= '0;
      uart_init   <= 1'b0;
      uart_enable <= 1'b0;
      vga_enable  <= 1'b1;
      cl_start    <= '0;
      wdog_error  <= 1'b0;
    end else begin
      uart_init   <= 1'b0;
      uart_enable <= 1'b0;
      cl_start    <= '0;
      case (r_state)
        S_IDLE: begin
          if (!uart_rx_n || load_req) begin
            uart_init  <= 1'b1;
            vga_enable <= 1'b0;
            r_state    <= S_UART_EN;
          end else if (decode_req) begin
            vga_enable <= 1'b0;
            r_idx      <= '0;
            r_state    <= S_CL_START;
          end
        end
        S_UART_EN: begin
          uart_enable <= 1'b1;
          r_state     <= S_UART_RX;
        end
        S_UART_RX: begin
          // An empty load (address still 0) keeps waiting for data
          if (w_expired && (uart_addr != '0)) begin
            uart_init <= 1'b1;
            r_idx     <= '0;
            r_state   <= S_CL_START;
          end
        end
        S_CL_START: begin
          cl_start <= w_onehot[NUM_CLIENTS-1:0];
          r_wdog   <= '0;
          r_state  <= S_CL_RUN;
        end
        S_CL_RUN: begin
          if (w_done_pad[r_idx]) begin
            if (r_idx == IDX_LAST) begin
              vga_enable <= 1'b1;
              r_state    <= S_IDLE;
            end else begin
              r_idx   <= r_idx + IDX_W'(1);
              r_state <= S_CL_START;
            end
          end else if (r_wdog == WDOG_LAST) begin
            wdog_error <= 1'b1;
            vga_enable <= 1'b1;
            r_state    <= S_IDLE;
          end else begin
            r_wdog <= r_wdog + WDOG_W'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // SRAM ownership: UART while loading, active client while decoding, VGA otherwise
  always_comb begin
    sram_addr  = vga_addr;
    sram_wdata = uart_wdata;
    sram_we_n  = 1'b1;
    case (r_state)
      S_UART_EN, S_UART_RX: begin
        sram_addr = uart_addr;
        sram_we_n = uart_we_n;
      end
      S_CL_RUN: begin
        sram_addr  = w_cl_addr_a[r_idx];
        sram_wdata = w_cl_wdata_a[r_idx];
        sram_we_n  = w_we_n_pad[r_idx];
      end
      default: ;
    endcase
    if (!resetn)
      sram_we_n = 1'b1;
  end

endmodule
